fnd_capture: RTL and testbench

- Receive-side decoder for the multiplexed 4-digit FND bus: monitors fnd_data/fnd_com as driven by the display controller and reconstructs the displayed 14-bit value.
- Decodes each stable digit dwell to BCD, collects all four digit slots, then converts BCD to binary sequentially.
- Used for display readback, self-check and bench scoreboarding; sits alongside the display controller on the same clock.

---
 rtl/fnd_capture.sv | 190 +++++++++++++++++++
 tb/tb_fnd_capture.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_capture.sv
// fnd_capture: receive-side decoder for the multiplexed 4-digit FND bus.
// It watches fnd_com/fnd_data and decodes each stable digit dwell to BCD.
// Once all four digit slots are filled, it converts the BCD digits to binary
// and reports the value on cnt_data, with a one-cycle cnt_valid pulse.
// Optional build macro: FND_CAPTURE_DP_EN. When it is defined, dp_mask tracks
// the decimal point of each slot. When it is undefined, dp_mask stays 0 and
// fnd_data[7] is ignored.
// dbg_state exposes the conversion FSM: 0=IDLE, 1=CONV, 2=DONE.
module fnd_capture #(
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  fnd_data,
  input  logic [3:0]  fnd_com,
  output logic [13:0] cnt_data,
  output logic        cnt_valid,
  output logic        seg_err,
  output logic        stale,
  output logic [3:0]  dp_mask,
  output logic [1:0]  dbg_state
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]    SETTLE_MAX  = 8'(SETTLE_CYC);
  localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] TO_MAX      = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYC - 1);
`ifdef FND_CAPTURE_DP_EN
  localparam logic [7:0] DATA_KEEP = 8'hFF;
`else
  // Without decimal-point tracking, bit7 is masked at the input register.
  // A dp toggle alone therefore never restarts a dwell.
  localparam logic [7:0] DATA_KEEP = 8'h7F;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  logic [7:0]    data_r, data_p;
  logic [3:0]    com_r, com_p;
  logic [7:0]    stab_cnt;
  logic [TW-1:0] to_cnt;
  logic [3:0]    slot_mask, mask_n;
  logic [3:0]    dig [4];
  logic [15:0]   snap;
  logic [13:0]   acc;
  logic [1:0]    conv_idx;
  logic          one_low, stable, capture, dec_ok;
  logic          cap_valid, cap_bad, timeout_hit, frame_go;
  logic [3:0]    dec_val;
  logic [1:0]    slot;

  assign dbg_state = state;

  // Map the registered commons to a slot index; anything not exactly one-low is blanking.
  always_comb begin
    one_low = 1'b1;
    slot    = 2'd0;
    case (com_r)
      4'b1110: slot = 2'd0;
      4'b1101: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b0111: slot = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  // Seven-segment (active-low, bit7 ignored) to BCD.
  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'd0;
    case (data_r[6:0])
      7'h40:   dec_val = 4'd0;
      7'h79:   dec_val = 4'd1;
      7'h24:   dec_val = 4'd2;
      7'h30:   dec_val = 4'd3;
      7'h19:   dec_val = 4'd4;
      7'h12:   dec_val = 4'd5;
      7'h02:   dec_val = 4'd6;
      7'h78:   dec_val = 4'd7;
      7'h00:   dec_val = 4'd8;
      7'h10:   dec_val = 4'd9;
      default: dec_ok  = 1'b0;
    endcase
  end

  assign stable      = one_low && (com_r == com_p) && (data_r == data_p);
  assign capture     = stable && (stab_cnt == SETTLE_LAST);
  assign cap_valid   = capture && dec_ok;
  assign cap_bad     = capture && !dec_ok;
  assign timeout_hit = !cap_valid && (to_cnt == TO_LAST);
  assign frame_go    = (slot_mask == 4'hF) && (state == S_IDLE);

  // Next slot mask: frame/timeout clear first, then this cycle's capture lands on top.
  always_comb begin
    mask_n = slot_mask;
    if (frame_go || timeout_hit) mask_n = 4'b0000;
    if (cap_valid)    mask_n[slot] = 1'b1;
    else if (cap_bad) mask_n[slot] = 1'b0;
  end

  // Input registers, dwell stability, digit capture, staleness timer and dp tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r    <= 8'hFF & DATA_KEEP;
      data_p    <= 8'hFF & DATA_KEEP;
      com_r     <= 4'hF;
      com_p     <= 4'hF;
      stab_cnt  <= 8'd0;
      to_cnt    <= '0;
      stale     <= 1'b1;
      slot_mask <= 4'b0000;
      seg_err   <= 1'b0;
      dp_mask   <= 4'b0000;
      dig[0]    <= 4'd0;
      dig[1]    <= 4'd0;
      dig[2]    <= 4'd0;
      dig[3]    <= 4'd0;
    end else begin
      data_r <= fnd_data & DATA_KEEP;
      data_p <= data_r;
      com_r  <= fnd_com;
      com_p  <= com_r;

      if (!stable)                   stab_cnt <= 8'd0;
      else if (stab_cnt < SETTLE_MAX) stab_cnt <= stab_cnt + 8'd1;

      seg_err   <= cap_bad;
      slot_mask <= mask_n;
      if (cap_valid) dig[slot] <= dec_val;

      if (cap_valid) begin
        to_cnt <= '0;
        stale  <= 1'b0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + TW'(1);
        if (timeout_hit) stale <= 1'b1;
      end

`ifdef FND_CAPTURE_DP_EN
      if (cap_valid) dp_mask[slot] <= ~data_r[7];
`else
      dp_mask <= 4'b0000;
`endif
    end
  end

  // Conversion FSM: snapshot the digits, run 4 multiply-accumulate steps (thousands first), then publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      snap      <= 16'd0;
      acc       <= 14'd0;
      conv_idx  <= 2'd0;
      cnt_data  <= 14'd0;
      cnt_valid <= 1'b0;
    end else begin
      cnt_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_go) begin
            snap     <= {dig[3], dig[2], dig[1], dig[0]};
            acc      <= 14'd0;
            conv_idx <= 2'd0;
            state    <= S_CONV;
          end
        end
        S_CONV: begin
          acc      <= (acc << 3) + (acc << 1) + {10'd0, snap[15:12]};
          snap     <= {snap[11:0], 4'd0};
          conv_idx <= conv_idx + 2'd1;
          if (conv_idx == 2'd3) state <= S_DONE;
        end
        S_DONE: begin
          cnt_data  <= acc;
          cnt_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fnd_capture.sv
// tb_fnd_capture: directed + randomized stimulus for fnd_capture.
// A cycle-indexed reference model predicts captures, frames, seg_err, stale and dp_mask.
module tb_fnd_capture;

  localparam int SETTLE = 4;
  localparam int TMO    = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  fnd_data;
  logic [3:0]  fnd_com;
  logic [13:0] cnt_data;
  logic        cnt_valid;
  logic        seg_err;
  logic        stale;
  logic [3:0]  dp_mask;
  logic [1:0]  dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  fnd_capture #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .fnd_data  (fnd_data),
    .fnd_com   (fnd_com),
    .cnt_data  (cnt_data),
    .cnt_valid (cnt_valid),
    .seg_err   (seg_err),
    .stale     (stale),
    .dp_mask   (dp_mask),
    .dbg_state (dbg_state)
  );

  typedef struct { int edge_no; logic [3:0] com; logic [7:0] data; } cap_t;
  typedef struct { int edge_no; int val; } frame_t;

  // scoreboard: expected captures and expected frame results, keyed by clock edge
  cap_t   cap_q[$];
  frame_t exp_q[$];

  logic [7:0]  seg_tab [10];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;

  int          m_dig [4];
  bit   [3:0]  m_mask;
  logic [3:0]  m_dp;
  bit          m_any_cap;
  int          m_ref;
  int          exp_cnt;
  logic [11:0] cur_key;
  int          run_t0;
  bit          run_done;

  function automatic int decode(input logic [7:0] d);
    for (int i = 0; i < 10; i++) begin
      if (d[6:0] == seg_tab[i][6:0]) return i;
    end
    return -1;
  endfunction

  function automatic int slot_of(input logic [3:0] c);
    case (c)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [11:0] key_of(input logic [3:0] c, input logic [7:0] d);
`ifdef FND_CAPTURE_DP_EN
    return {c, d};
`else
    return {c, 1'b0, d[6:0]};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    cap_q.delete();
    exp_q.delete();
    m_mask    = 4'b0000;
    m_dp      = 4'b0000;
    m_any_cap = 1'b0;
    m_ref     = cyc;
    exp_cnt   = 0;
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
    cur_key   = key_of(4'hF, 8'hFF);
    run_done  = 1'b1;
  endtask

  task automatic apply_cap(input cap_t c, output bit seg);
    int d;
    int s;
    seg = 1'b0;
    d = decode(c.data);
    s = slot_of(c.com);
    if (d < 0) begin
      seg       = 1'b1;
      m_mask[s] = 1'b0;
    end else begin
      m_dig[s]  = d;
      m_mask[s] = 1'b1;
      m_any_cap = 1'b1;
      m_ref     = cyc;
`ifdef FND_CAPTURE_DP_EN
      m_dp[s]   = ~c.data[7];
`endif
      if (m_mask == 4'hF) begin
        exp_q.push_back('{cyc + 6, m_dig[3] * 1000 + m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0]});
        m_mask = 4'b0000;
      end
    end
  endtask

  // One clock: advance the model to this edge, then compare every output.
  task automatic tick();
    bit     exp_seg;
    bit     exp_valid;
    bit     exp_stale;
    bit     s;
    cap_t   c;
    frame_t f;
    @(posedge clk);
    cyc++;
    exp_seg   = 1'b0;
    exp_valid = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      while (cap_q.size() > 0 && cap_q[0].edge_no == cyc) begin
        c = cap_q.pop_front();
        apply_cap(c, s);
        if (s) exp_seg = 1'b1;
      end
      if (cyc - m_ref == TMO) m_mask = 4'b0000;
      if (exp_q.size() > 0 && exp_q[0].edge_no == cyc) begin
        f = exp_q.pop_front();
        exp_valid = 1'b1;
        exp_cnt   = f.val;
      end
    end
    exp_stale = !m_any_cap || (cyc - m_ref >= TMO);
    #1;
    check("cnt_valid", cnt_valid, exp_valid);
    check("cnt_data",  cnt_data,  exp_cnt);
    check("seg_err",   seg_err,   exp_seg);
    check("stale",     stale,     exp_stale);
    check("dp_mask",   dp_mask,   m_dp);
  endtask

  // driver: hold one bus value for len cycles and predict its capture edge
  task automatic drive(input logic [3:0] c, input logic [7:0] d, input int len);
    logic [11:0] k;
    k = key_of(c, d);
    fnd_com  = c;
    fnd_data = d;
    if (k != cur_key) begin
      cur_key  = k;
      run_t0   = cyc + 1;
      run_done = 1'b0;
    end
    if (!run_done && slot_of(c) >= 0 && (run_t0 + SETTLE <= cyc + len)) begin
      cap_q.push_back('{run_t0 + 1 + SETTLE, c, d});
      run_done = 1'b1;
    end
    repeat (len) tick();
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b1;
    fnd_com  = 4'hF;
    fnd_data = 8'hFF;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic scan(input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2, input logic [7:0] d3, input int len);
    drive(4'b1110, d0, len);
    drive(4'b1101, d1, len);
    drive(4'b1011, d2, len);
    drive(4'b0111, d3, len);
  endtask

  task automatic scan_val(input int v, input int len);
    scan(seg_tab[v % 10], seg_tab[(v / 10) % 10], seg_tab[(v / 100) % 10], seg_tab[v / 1000], len);
  endtask

  initial begin
    logic [3:0] rc;
    logic [7:0] rd;
    int         r;
    seg_tab  = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    rst      = 1'b1;
    fnd_com  = 4'hF;
    fnd_data = 8'hFF;
    model_reset();

    do_reset(4);
    check("reset_cnt_data", cnt_data, 0);
    check("reset_stale", stale, 1);

    // long dwells, value 1234
    scan_val(1234, 1000);
    drive(4'hF, 8'hFF, 10);
    check("frame_1234", cnt_data, 14'h4D2);

    scan_val(9999, 20);
    drive(4'hF, 8'hFF, 10);
    check("frame_9999", cnt_data, 9999);
    scan_val(0, 20);
    drive(4'hF, 8'hFF, 10);
    check("frame_0000", cnt_data, 0);
    check("stale_while_scanning", stale, 0);

    // blank thousands digit spoils the frame, next clean frame 0507
    scan(seg_tab[1], seg_tab[2], seg_tab[3], 8'hFF, 20);
    check("no_frame_after_blank", cnt_data, 0);
    scan_val(507, 20);
    drive(4'hF, 8'hFF, 10);
    check("frame_0507", cnt_data, 507);

    // glitchy commons and too-short dwells, then a clean frame
    drive(4'b1100, seg_tab[8], 2);
    drive(4'b1110, seg_tab[4], 3);
    drive(4'b1101, seg_tab[6], 2);
    drive(4'b1100, seg_tab[1], 2);
    drive(4'b1011, seg_tab[7], SETTLE);
    scan_val(8642, 12);
    drive(4'hF, 8'hFF, 10);
    check("frame_after_glitch", cnt_data, 8642);

    // dwell boundary: SETTLE+1 cycles captures, SETTLE cycles does not
    scan_val(3141, SETTLE + 1);
    drive(4'hF, 8'hFF, 10);
    check("frame_min_dwell", cnt_data, 3141);
    scan_val(2718, SETTLE);
    drive(4'hF, 8'hFF, 10);
    check("no_frame_short_dwell", cnt_data, 3141);

    // randomized bus traffic
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       rc = ~(4'b0001 << $urandom_range(0, 3));
      else if (r == 7) rc = 4'hF;
      else             rc = 4'($urandom_range(0, 15));
      rd = seg_tab[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) rd = 8'($urandom_range(0, 255));
      rd[7] = 1'($urandom_range(0, 1));
      drive(rc, rd, $urandom_range(1, 12));
    end

    // stop scanning: stale rises exactly TMO cycles after the last capture, value held
    drive(4'hF, 8'hFF, TMO + 20);
    check("stale_after_timeout", stale, 1);
    check("held_after_timeout", cnt_data, exp_cnt);

    // tens digit with its decimal point lit
    scan(seg_tab[5], 8'h24, seg_tab[1], seg_tab[0], 12);
    drive(4'hF, 8'hFF, 10);
    check("frame_0125_dp", cnt_data, 125);
`ifdef FND_CAPTURE_DP_EN
    check("dp_mask_tens", dp_mask, 4'b0010);
`else
    check("dp_mask_off", dp_mask, 4'b0000);
`endif

    // reset while converting: no result, outputs back to reset values
    drive(4'b1110, seg_tab[1], 10);
    drive(4'b1101, seg_tab[2], 10);
    drive(4'b1011, seg_tab[3], 10);
    drive(4'b0111, seg_tab[4], SETTLE + 1);
    drive(4'hF, 8'hFF, 3);
    do_reset(2);
    check("reset_mid_conv_data", cnt_data, 0);
    drive(4'hF, 8'hFF, 12);
    check("reset_mid_conv_stale", stale, 1);

    scan_val(6060, 8);
    drive(4'hF, 8'hFF, 10);
    check("frame_after_reset", cnt_data, 6060);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
